// File: rtl/uart_msg_seq.sv
// uart_msg_seq: streams one of MSG_COUNT NUL-terminated messages from a
// 512x8 ROM image into a UART transmitter, one byte per cts handshake.
// Supports run-time message select, one-shot or repeat mode with a fixed
// inter-message gap, and abort from any active state.
module uart_msg_seq #(
  parameter int    MSG_COUNT  = 4,
  parameter int    MSG_STRIDE = 64,
  parameter int    GAP_CYCLES = 16,
  parameter string INIT_FILE  = "obj/messages.hex"
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [$clog2(MSG_COUNT)-1:0] i_msg_sel,
  input  logic                         i_repeat,
  input  logic                         i_abort,
  input  logic                         i_cts,
  input  logic                         i_idle,
  output logic [7:0]                   o_data,
  output logic                         o_req,
  output logic                         o_done,
  output logic                         o_busy,
  output logic [7:0]                   o_msg_count
);

  localparam int SEL_W = $clog2(MSG_COUNT);
  localparam int CUR_W = $clog2(MSG_STRIDE);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(MSG_STRIDE - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CUR_W-1:0] cursor_reg, cursor_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic             rpt_reg, rpt_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic [7:0]       count_reg, count_next;
  logic             msg_end;

  // Message ROM. Contents are the image named by INIT_FILE, applied as the
  // memory initialisation by the implementation flow; the logic only reads it.
  logic [7:0] rom [0:511];
  logic [8:0] addr;
  logic [7:0] rd_data;

  // Stride is a power of two, so sel*MSG_STRIDE + cursor is a concatenation.
  // Both fields are registers, so the address only moves on a clock edge.
  assign addr = 9'({sel_reg, cursor_reg});

  // Registered ROM read: data for a new address is valid one cycle later,
  // which is what the FETCH bubble waits out.
  always_ff @(posedge clk) begin
    rd_data <= rom[addr];
  end

  assign o_data      = rd_data;
  assign o_msg_count = count_reg;

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cursor_reg <= '0;
      sel_reg    <= '0;
      rpt_reg    <= 1'b0;
      gap_reg    <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cursor_reg <= cursor_next;
      sel_reg    <= sel_next;
      rpt_reg    <= rpt_next;
      gap_reg    <= gap_next;
      count_reg  <= count_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next  = state_reg;
    cursor_next = cursor_reg;
    sel_next    = sel_reg;
    rpt_next    = rpt_reg;
    gap_next    = gap_reg;
    count_next  = count_reg;
    msg_end     = 1'b0;
    o_req       = 1'b0;
    o_done      = 1'b0;
    o_busy      = (state_reg != S_IDLE);

    case (state_reg)
      S_IDLE: begin
        if (i_start) begin
          sel_next    = i_msg_sel;
          rpt_next    = i_repeat;
          count_next  = '0;
          cursor_next = '0;
          state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_abort)     state_next = S_DONE;
        else if (i_idle) state_next = S_FETCH;
      end
      S_FETCH: begin
        state_next = i_abort ? S_DONE : S_SEND;
      end
      S_SEND: begin
        if (rd_data == 8'h00) begin
          // NUL terminator is never requested; the message ends here
          // unless an abort takes precedence.
          if (i_abort) state_next = S_DONE;
          else         msg_end    = 1'b1;
        end else begin
          o_req = 1'b1;
          if (i_cts) begin
            // The byte is accepted even when abort arrives with it.
            cursor_next = cursor_reg + 1'b1;
            if (i_abort)                    state_next = S_DONE;
            else if (cursor_reg == CUR_LAST) msg_end    = 1'b1;
            else                             state_next = S_FETCH;
          end else if (i_abort) begin
            state_next = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (i_abort)              state_next = S_DONE;
        else if (gap_reg == '0)   state_next = S_WAIT;
        else                      gap_next   = gap_reg - 1'b1;
      end
      S_DONE: begin
        o_done     = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Common end-of-message handling for NUL and full-stride endings.
    if (msg_end) begin
      count_next  = count_reg + 8'd1;
      cursor_next = '0;
      if (rpt_reg) begin
        state_next = S_GAP;
        gap_next   = GAP_LOAD;
      end else begin
        state_next = S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_uart_msg_seq.sv
// Directed self-checking bench for uart_msg_seq. The ROM is preloaded with:
// msg0 = 64 bytes 0x80..0xBF (no NUL), msg1 = "Hi\n\0", msg2 = "AB\0",
// msg3 = "" (first byte NUL).
module tb_uart_msg_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [1:0] i_msg_sel = 2'd0;
  logic       i_repeat = 1'b0;
  logic       i_abort = 1'b0;
  logic       i_cts = 1'b0;
  logic       i_idle = 1'b1;
  logic [7:0] o_data;
  logic       o_req;
  logic       o_done;
  logic       o_busy;
  logic [7:0] o_msg_count;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] got[$];
  int done_cnt;

  uart_msg_seq #(
    .MSG_COUNT (4),
    .MSG_STRIDE(64),
    .GAP_CYCLES(16),
    .INIT_FILE ("obj/messages.hex")
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_msg_sel  (i_msg_sel),
    .i_repeat   (i_repeat),
    .i_abort    (i_abort),
    .i_cts      (i_cts),
    .i_idle     (i_idle),
    .o_data     (o_data),
    .o_req      (o_req),
    .o_done     (o_done),
    .o_busy     (o_busy),
    .o_msg_count(o_msg_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_rom();
    for (int i = 0; i < 512; i++) dut.rom[i] = 8'h00;
    for (int i = 0; i < 64; i++) dut.rom[i] = 8'(8'h80 + i);
    dut.rom[64] = 8'h48; dut.rom[65] = 8'h69; dut.rom[66] = 8'h0A; dut.rom[67] = 8'h00;
    dut.rom[128] = 8'h41; dut.rom[129] = 8'h42; dut.rom[130] = 8'h00;
    dut.rom[192] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_msg(input logic [1:0] sel, input logic rpt);
    @(negedge clk);
    i_msg_sel = sel; i_repeat = rpt; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Acts as the TX block: answers each o_req with a one-cycle cts.
  // Returns at the negedge where o_done is seen, or on timeout.
  task automatic collect(input int max_cyc, output bit timeout);
    timeout = 1'b1; got.delete(); done_cnt = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      i_cts = 1'b0;
      if (o_done) begin done_cnt++; timeout = 1'b0; break; end
      if (o_req) begin got.push_back(o_data); i_cts = 1'b1; end
    end
    i_cts = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", o_req); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_checks++; if (o_msg_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_msg_count); end
    $display("test_reset: outputs req=%b done=%b busy=%b count=%0d", o_req, o_done, o_busy, o_msg_count);
  endtask

  task automatic test_hi();
    bit to;
    logic [7:0] exp [3];
    logic [7:0] g;
    exp[0] = 8'h48; exp[1] = 8'h69; exp[2] = 8'h0A;
    start_msg(2'd1, 1'b0);
    collect(100, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL hi_timeout: no o_done within 100 cycles"); end
    n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL hi_len: got %0d bytes want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      g = (i < got.size()) ? got[i] : 8'h00;
      n_checks++; if (g !== exp[i]) begin n_fail++; $display("FAIL hi_byte%0d: got %h want %h", i, g, exp[i]); end
    end
    n_checks++; if (o_msg_count !== 8'd1) begin n_fail++; $display("FAIL hi_count: got %0d want 1", o_msg_count); end
    n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL hi_busy_in_done: got %b want 1", o_busy); end
    @(negedge clk);
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL hi_done_width: got %b want 0", o_done); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL hi_busy_after: got %b want 0", o_busy); end
    $display("test_hi: sent %0d bytes, done pulses %0d, count %0d", got.size(), done_cnt, o_msg_count);
  endtask

  task automatic test_long();
    bit to;
    int bad;
    start_msg(2'd0, 1'b0);
    collect(400, to);
    bad = 0;
    foreach (got[i]) if (got[i] !== 8'(8'h80 + i)) bad++;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL long_timeout: no o_done within 400 cycles"); end
    n_checks++; if (got.size() != 64) begin n_fail++; $display("FAIL long_len: got %0d bytes want 64", got.size()); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL long_bytes: got %0d wrong bytes want 0", bad); end
    n_checks++; if (o_msg_count !== 8'd1) begin n_fail++; $display("FAIL long_count: got %0d want 1", o_msg_count); end
    $display("test_long: sent %0d bytes, count %0d", got.size(), o_msg_count);
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    bit to;
    start_msg(2'd3, 1'b0);
    collect(20, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL zero_timeout: no o_done within 20 cycles"); end
    n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL zero_len: got %0d requests want 0", got.size()); end
    n_checks++; if (o_msg_count !== 8'd1) begin n_fail++; $display("FAIL zero_count: got %0d want 1", o_msg_count); end
    $display("test_zero_len: requests %0d, count %0d", got.size(), o_msg_count);
    @(negedge clk);
  endtask

  task automatic test_repeat();
    int req_cyc[$];
    logic [7:0] cnt_q[$];
    int done_seen, bad;
    bit reached;
    got.delete(); done_seen = 0; reached = 1'b0;
    start_msg(2'd2, 1'b1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      i_cts = 1'b0;
      if (o_done) done_seen++;
      if (o_req) begin
        got.push_back(o_data); req_cyc.push_back(c); cnt_q.push_back(o_msg_count);
        i_cts = 1'b1;
        if (got.size() == 7) begin reached = 1'b1; break; end
      end
    end
    @(negedge clk);
    i_cts = 1'b0; i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    n_checks++; if (reached !== 1'b1) begin n_fail++; $display("FAIL rep_timeout: got %0d bytes want 7", got.size()); end
    bad = 0;
    foreach (got[i]) if (got[i] !== ((i % 2 == 0) ? 8'h41 : 8'h42)) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rep_bytes: got %0d wrong bytes want 0", bad); end
    if (reached) begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (cnt_q[2*k] !== 8'(k)) begin n_fail++; $display("FAIL rep_count%0d: got %0d want %0d", k, cnt_q[2*k], k); end
      end
      n_checks++;
      if (req_cyc[2] - req_cyc[1] != 21) begin n_fail++; $display("FAIL rep_gap: got %0d cycles want 21", req_cyc[2] - req_cyc[1]); end
    end
    n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL rep_early_done: got %0d pulses want 0", done_seen); end
    n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL rep_abort_done: got %b want 1", o_done); end
    n_checks++; if (o_msg_count !== 8'd3) begin n_fail++; $display("FAIL rep_abort_count: got %0d want 3", o_msg_count); end
    $display("test_repeat: %0d bytes, final count %0d", got.size(), o_msg_count);
    @(negedge clk);
  endtask

  task automatic test_abort_cts();
    bit to;
    to = 1'b1; got.delete();
    start_msg(2'd1, 1'b0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      i_cts = 1'b0; i_abort = 1'b0;
      if (o_done) begin to = 1'b0; break; end
      if (o_req) begin
        got.push_back(o_data); i_cts = 1'b1;
        if (got.size() == 2) i_abort = 1'b1;
      end
    end
    i_cts = 1'b0; i_abort = 1'b0;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL abort_timeout: no o_done within 50 cycles"); end
    n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL abort_len: got %0d bytes want 2", got.size()); end
    n_checks++; if (o_msg_count !== 8'd0) begin n_fail++; $display("FAIL abort_count: got %0d want 0", o_msg_count); end
    @(negedge clk);
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", o_busy); end
    $display("test_abort_cts: %0d bytes, count %0d", got.size(), o_msg_count);
  endtask

  task automatic test_idle_hold();
    int bad_req, bad_busy, bad_hold;
    bit seen;
    i_idle = 1'b0;
    start_msg(2'd1, 1'b0);
    bad_req = 0; bad_busy = 0;
    // cts held high and a stray start with another select must both be ignored.
    i_cts = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_req) bad_req++;
      if (!o_busy) bad_busy++;
      i_start = (c == 3); i_msg_sel = 2'd0;
    end
    i_start = 1'b0; i_cts = 1'b0; i_idle = 1'b1;
    n_checks++; if (bad_req != 0) begin n_fail++; $display("FAIL idle_req: got %0d req cycles want 0", bad_req); end
    n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL idle_busy: got %0d non-busy cycles want 0", bad_busy); end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (o_req) begin seen = 1'b1; break; end end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL idle_first_req: no o_req within 10 cycles"); end
    n_checks++; if (o_data !== 8'h48) begin n_fail++; $display("FAIL idle_first_byte: got %h want 48", o_data); end
    bad_hold = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_req !== 1'b1 || o_data !== 8'h48) bad_hold++;
    end
    n_checks++; if (bad_hold != 0) begin n_fail++; $display("FAIL idle_hold: got %0d unstable cycles want 0", bad_hold); end
    i_cts = 1'b1;
    @(negedge clk);
    i_cts = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (o_req) begin seen = 1'b1; break; end end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL idle_second_req: no o_req within 10 cycles"); end
    n_checks++; if (o_data !== 8'h69) begin n_fail++; $display("FAIL idle_second_byte: got %h want 69", o_data); end
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL idle_abort_done: got %b want 1", o_done); end
    $display("test_idle_hold: stall and hold sequence complete, count %0d", o_msg_count);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit found, to;
    logic [7:0] g;
    found = 1'b0;
    start_msg(2'd2, 1'b1);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      i_cts = 1'b0;
      if (o_req && o_msg_count == 8'd1) begin found = 1'b1; break; end
      if (o_req) i_cts = 1'b1;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rst_setup: count 1 with o_req not reached"); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_req: got %b want 0", o_req); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", o_busy); end
    n_checks++; if (o_msg_count !== 8'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d want 0", o_msg_count); end
    @(negedge clk);
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", o_done); end
    rst_n = 1'b1;
    start_msg(2'd1, 1'b0);
    collect(100, to);
    g = (got.size() > 0) ? got[0] : 8'h00;
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rst_restart_timeout: no o_done within 100 cycles"); end
    n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL rst_restart_len: got %0d bytes want 3", got.size()); end
    n_checks++; if (g !== 8'h48) begin n_fail++; $display("FAIL rst_restart_byte0: got %h want 48", g); end
    $display("test_reset_mid: restart sent %0d bytes, first %h", got.size(), g);
    @(negedge clk);
  endtask

  initial begin
    load_rom();
    test_reset();
    test_hi();
    test_long();
    test_zero_len();
    test_repeat();
    test_abort_cts();
    test_idle_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_msg_seq.md
Name: uart_msg_seq

Overview:
- Parametrised successor to the single fixed-message UART sender.
- Streams one of MSG_COUNT NUL-terminated messages from a block-RAM image into the UART transmitter, one byte per cts handshake.
- Supports run-time message select, one-shot or repeat mode with a programmable inter-message gap, and abort.
- Sits between the top-level control and the UART TX block; drives the TX block's data/req inputs and consumes its cts/idle.

Parameters:
- MSG_COUNT, 4, number of messages in the ROM image; must be >= 2.
- MSG_STRIDE, 64, bytes reserved per message; power of two; MSG_COUNT*MSG_STRIDE <= 512.
- GAP_CYCLES, 16, idle clocks between repeats; must be >= 1.
- INIT_FILE, "obj/messages.hex", ROM image for the internal blockram_512x8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_msg_sel  in  $clog2(MSG_COUNT)  message index; latched with i_start.
- i_repeat  in  1  repeat mode; latched with i_start.
- i_abort  in  1  stop request; honoured in any non-IDLE state.
- i_cts  in  1  TX accepted current byte.
- i_idle  in  1  TX idle.
- o_data  out  8  byte to send (blockram read data).
- o_req  out  1  byte valid request.
- o_done  out  1  one-cycle pulse at end of sequence.
- o_busy  out  1  high in every state except IDLE.
- o_msg_count  out  8  completed messages since start; wraps 255->0.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: state=IDLE, cursor=0, sel=0, repeat=0, gap counter=0, o_msg_count=0. Resulting outputs: o_req=0, o_done=0, o_busy=0.
- Reset mid-message drops the in-flight byte; no o_done is produced.
- RAM address = sel*MSG_STRIDE + cursor, 9 bits, registered. Read data is valid the cycle after the address changes.
- States and transitions:
  - IDLE: i_start -> latch sel and repeat, clear o_msg_count, cursor=0 -> WAIT.
  - WAIT: i_idle -> FETCH.
  - FETCH: one-cycle bubble for RAM latency -> SEND.
  - SEND, o_data != 0x00: o_req=1. o_req and o_data stay stable until i_cts.
  - SEND, i_cts: cursor+1 -> FETCH. If cursor == MSG_STRIDE-1, the byte is sent and the message ends.
  - SEND, o_data == 0x00: NUL terminator; o_req=0, the NUL is never sent; message ends next cycle.
  - Message end: o_msg_count+1. If repeat -> GAP with counter=GAP_CYCLES-1, cursor=0. Otherwise -> DONE.
  - GAP: decrement each cycle; at 0 -> WAIT.
  - DONE: o_done=1 for exactly one cycle -> IDLE.
- i_abort in WAIT, FETCH, SEND or GAP -> DONE next cycle; o_msg_count is not incremented.
- i_abort and i_cts together in SEND: the byte counts as accepted (cursor advances), then DONE.
- i_start outside IDLE is ignored. i_msg_sel and i_repeat changes after latch are ignored.
- i_cts outside SEND, or while o_req=0, is ignored.
- Zero-length message (first byte NUL): no o_req, message still counted.
- Throughput: at most one byte per 2 clocks (FETCH bubble); the cts handshake governs real rate.

Test Plan:
- Msg 1 = "Hi\n\0", i_repeat=0, i_idle=1, i_cts pulsed one cycle after each o_req -> bytes 0x48, 0x69, 0x0A in order, no 0x00 sent; o_done pulses once; o_msg_count=1; o_busy falls the cycle after o_done.
- Msg 0 filled with 64 non-NUL bytes -> exactly 64 requests, then DONE. Confirm the cursor does not spill into msg 1's bytes.
- i_repeat=1, GAP_CYCLES=16, msg 2 = "AB\0" -> "AB" repeats. Exactly 16 clocks of GAP between the last cts and the next WAIT. o_msg_count reads 1, 2, 3...; no o_done until abort.
- i_abort asserted together with i_cts on the 2nd byte of "Hi\n" -> 2 bytes sent, o_done pulses, o_msg_count=0.
- i_idle held low for 10 cycles after start -> o_req stays 0 until i_idle rises. o_req held stable with cts withheld for 20 cycles, then one byte advance.
- rst_n dropped mid-SEND (asynchronously, between clock edges) -> o_req, o_busy, o_msg_count go to 0 immediately. After release, a new i_start sends a message from byte 0.
